pagerank_contrib_accum: RTL

Parametrised, multi-lane successor to the single-channel PageRank division stage. Accepts a stream of (page-rank, out-degree) pairs for one destination node and divides each in one of `LANES` serial dividers. Sums the quotients into that node's new rank and presents the result with a valid/ready handshake. Sits between the rank/degree BRAM readers and the rank write-back logic.

---
 rtl/pagerank_pkg.sv | 12 +
 rtl/pr_serial_div.sv | 53 +++++
 rtl/pagerank_contrib_accum.sv | 112 +++++++++++
 3 files changed

// File: rtl/pagerank_pkg.sv
// pagerank_pkg: shared FSM state type and width helpers for the PageRank contribution accumulator
package pagerank_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} pr_state_t;

    function automatic int acc_w(input int data_w, input int cnt_w);
        return data_w + cnt_w;
    endfunction

    function automatic int lane_w(input int lanes);
        return lanes > 1 ? $clog2(lanes) : 1;
    endfunction
endpackage

// File: rtl/pr_serial_div.sv
// pr_serial_div: one restoring radix-2 divider lane, one quotient bit per cycle, DATA_W cycles per divide.
module pr_serial_div #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic              dz
);
    localparam int CW = $clog2(DATA_W + 1);
    logic [CW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_rem, r_q, r_div;
    logic              r_done, r_dz;
    logic [DATA_W:0]   w_trial, w_diff;
    logic              w_ge;
    assign w_trial  = {r_rem, r_q[DATA_W-1]};
    assign w_ge     = w_trial >= {1'b0, r_div};
    assign w_diff   = w_ge ? w_trial - {1'b0, r_div} : w_trial;
    assign busy     = r_cnt != '0;
    assign done     = r_done;
    assign dz       = r_dz;
    // a zero divisor is a dangling node: it contributes nothing to the rank
    assign quotient = r_dz ? '0 : r_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_rem  <= '0;
            r_q    <= '0;
            r_div  <= '0;
            r_done <= 1'b0;
            r_dz   <= 1'b0;
        end else if (load) begin
            r_cnt  <= CW'(DATA_W);
            r_rem  <= '0;
            r_q    <= dividend;
            r_div  <= divisor;
            r_done <= 1'b0;
            r_dz   <= divisor == '0;
        end else begin
            r_done <= r_cnt == CW'(1);
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
                r_rem <= w_diff[DATA_W-1:0];
                r_q   <= {r_q[DATA_W-2:0], w_ge};
            end
        end
    end
endmodule

// File: rtl/pagerank_contrib_accum.sv
// pagerank_contrib_accum: divides (rank, out-degree) pairs across LANES serial dividers and sums the quotients.
// Define PR_ACC_SAT_EN to saturate the result at 2^DATA_W-1 instead of wrapping.
module pagerank_contrib_accum
    import pagerank_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANES  = 4,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  ip_count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] page_rank_bram,
    input  logic [DATA_W-1:0] out_deg_bram,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] final_pagerank,
    output logic              div_zero,
    output logic              busy
);
`ifdef PR_ACC_SAT_EN
    localparam int ACC_W = acc_w(DATA_W, CNT_W);
`else
    localparam int ACC_W = DATA_W;  // the wrapped result only depends on the low bits
`endif
    localparam int LW = lane_w(LANES);
    pr_state_t         r_state, w_next;
    logic [CNT_W-1:0]  r_count, r_issued, r_cpl;
    logic [ACC_W-1:0]  r_acc;
    logic              r_dz;
    logic [LANES-1:0]  w_busy, w_done, w_dz;
    logic [DATA_W-1:0] w_q [LANES];
    logic [DATA_W-1:0] w_qsum;
    logic [LW-1:0]     w_sel;
    logic              w_any_free, w_accept, w_cpl;
    assign in_ready  = r_state == RUN && w_any_free && r_issued < r_count;
    assign w_accept  = in_valid && in_ready;
    assign w_cpl     = |w_done;
    assign out_valid = r_state == DONE;
    assign busy      = r_state != IDLE;
    assign div_zero  = r_dz;
`ifdef PR_ACC_SAT_EN
    assign final_pagerank = |r_acc[ACC_W-1:DATA_W] ? '1 : r_acc[DATA_W-1:0];
`else
    assign final_pagerank = r_acc[DATA_W-1:0];
`endif
    // fixed latency means at most one lane completes per cycle, so OR-merging is exact
    always_comb begin
        w_sel      = '0;
        w_any_free = 1'b0;
        w_qsum     = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (!w_busy[i]) begin
                w_sel      = LW'(i);
                w_any_free = 1'b1;
            end
            if (w_done[i]) w_qsum = w_qsum | w_q[i];
        end
    end
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        pr_serial_div #(.DATA_W(DATA_W)) u_div (
            .clk      (clk),
            .reset    (reset),
            .load     (w_accept && w_sel == LW'(i)),
            .dividend (page_rank_bram),
            .divisor  (out_deg_bram),
            .busy     (w_busy[i]),
            .done     (w_done[i]),
            .quotient (w_q[i]),
            .dz       (w_dz[i])
        );
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = ip_count == '0 ? DONE : RUN;
            RUN:     if (w_cpl && r_cpl + CNT_W'(1) == r_count) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count  <= '0;
            r_issued <= '0;
            r_cpl    <= '0;
            r_acc    <= '0;
            r_dz     <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_count  <= ip_count;
            r_issued <= '0;
            r_cpl    <= '0;
            r_acc    <= '0;
            r_dz     <= 1'b0;
        end else begin
            if (w_accept) r_issued <= r_issued + CNT_W'(1);
            if (r_state == RUN && w_cpl) begin
                r_acc <= r_acc + ACC_W'(w_qsum);
                r_cpl <= r_cpl + CNT_W'(1);
                if (|(w_done & w_dz)) r_dz <= 1'b1;
            end
            if (r_state == DONE && out_ready) r_dz <= 1'b0;
        end
    end
endmodule
